// File: rtl/cordic_hyp_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cordic_hyp_pkg                                             |
// | Description : Shared types, constants and schedule helpers for the       |
// |               hyperbolic CORDIC engine.                                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package cordic_hyp_pkg;

  typedef enum logic [1:0] {
    MODE_EXP  = 2'd0,
    MODE_SINH = 2'd1,
    MODE_COSH = 2'd2,
    MODE_LN   = 2'd3
  } hyp_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_FIN  = 2'd3
  } hyp_state_e;

  // Reference constants are held at Q24 and requantised to the target precision.
  localparam int c_ref_frac    = 24;
  localparam int c_inv_kh_ref  = 20258439;  // 1.2074970678
  localparam int c_rot_max_ref = 18760283;  // 1.1182
  localparam int c_ln_min_ref  = 1793484;   // 0.1069

  function automatic int requant(input int v, input int frac);
    int r;
    if (frac >= c_ref_frac) r = v <<< (frac - c_ref_frac);
    else r = (v + (1 <<< (c_ref_frac - frac - 1))) >>> (c_ref_frac - frac);
    return r;
  endfunction

  // Beyond i=7 the series term 2^-3i/3 falls below one Q24 LSB.
  function automatic int atanh_ref(input int i);
    int r;
    case (i)
      1:       r = 9215828;
      2:       r = 4285116;
      3:       r = 2108178;
      4:       r = 1049945;
      5:       r = 524459;
      6:       r = 262165;
      7:       r = 131075;
      default: r = (i >= 8 && i <= c_ref_frac) ? (1 <<< (c_ref_frac - i)) : 0;
    endcase
    return r;
  endfunction

  function automatic int atanh_fg(input int i, input int fg);
    return requant(atanh_ref(i), fg);
  endfunction

  function automatic bit is_repeat(input int i);
    return (i == 4) || (i == 13) || (i == 40);
  endfunction

  function automatic int total_steps(input int iter);
    int n;
    n = iter;
    if (iter >= 4)  n = n + 1;
    if (iter >= 13) n = n + 1;
    if (iter >= 40) n = n + 1;
    return n;
  endfunction

  function automatic int shift_of_step(input int step, input int iter);
    int k;
    int res;
    k   = 0;
    res = iter;
    for (int i = 1; i <= iter; i++) begin
      if (k == step) res = i;
      k = k + 1;
      if (is_repeat(i)) begin
        if (k == step) res = i;
        k = k + 1;
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cordic_hyp_step.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cordic_hyp_step                                            |
// | Description : One combinational hyperbolic CORDIC micro-rotation.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module cordic_hyp_step
  import cordic_hyp_pkg::*;
#(
  parameter int WI  = 22,
  parameter int SHW = 6
) (
  input  logic signed [WI-1:0] i_x,
  input  logic signed [WI-1:0] i_y,
  input  logic signed [WI-1:0] i_z,
  input  logic [SHW-1:0]       i_shift,
  input  logic signed [WI-1:0] i_atanh,
  input  logic                 i_vec,
  output logic signed [WI-1:0] o_x,
  output logic signed [WI-1:0] o_y,
  output logic signed [WI-1:0] o_z
);

  logic                 w_pos;
  logic signed [WI-1:0] w_xs;
  logic signed [WI-1:0] w_ys;

  // Vectoring drives Y toward zero; rotation drives Z toward zero.
  assign w_pos = i_vec ? i_y[WI-1] : ~i_z[WI-1];
  assign w_xs  = i_x >>> i_shift;
  assign w_ys  = i_y >>> i_shift;

  assign o_x = w_pos ? (i_x + w_ys) : (i_x - w_ys);
  assign o_y = w_pos ? (i_y + w_xs) : (i_y - w_xs);
  assign o_z = w_pos ? (i_z - i_atanh) : (i_z + i_atanh);

endmodule
`default_nettype wire

// File: rtl/cordic_hyp_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cordic_hyp_engine                                          |
// | Description : Iterative hyperbolic CORDIC computing exp/sinh/cosh/ln.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module cordic_hyp_engine
  import cordic_hyp_pkg::*;
#(
  parameter int W     = 16,
  parameter int FRAC  = 12,
  parameter int GUARD = 4,
  parameter int ITER  = 14
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic [W-1:0] x_in,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [W-1:0] result
);

  localparam int WI  = W + GUARD + 2;
  localparam int FG  = FRAC + GUARD;
  localparam int S   = total_steps(ITER);
  localparam int STW = (S > 1) ? $clog2(S) : 1;
  localparam int SHW = 6;
  localparam int EXT = WI - W - GUARD;

  localparam logic signed [WI-1:0] c_inv_kh  = WI'(requant(c_inv_kh_ref, FG));
  localparam logic signed [WI-1:0] c_one     = WI'(1 <<< FG);
  localparam logic signed [W-1:0]  c_rot_max = W'(requant(c_rot_max_ref, FRAC));
  localparam logic signed [W-1:0]  c_ln_min  = W'(requant(c_ln_min_ref, FRAC));
  localparam logic signed [WI+1:0] c_half    = (WI+2)'(1 <<< (GUARD - 1));
  localparam logic signed [WI+1:0] c_res_max = (WI+2)'((1 <<< (W - 1)) - 1);
  localparam logic signed [WI+1:0] c_res_min = -c_res_max - (WI+2)'(1);

  hyp_state_e           r_state;
  hyp_state_e           w_next;
  hyp_mode_e            r_mode;
  logic signed [W-1:0]  r_x;
  logic signed [WI-1:0] r_xr;
  logic signed [WI-1:0] r_yr;
  logic signed [WI-1:0] r_zr;
  logic [STW-1:0]       r_step;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_err;
  logic [W-1:0]         r_result;

  logic                 w_accept;
  logic                 w_is_ln;
  logic                 w_range_bad;
  logic                 w_last;
  logic signed [WI-1:0] w_x_ext;
  logic signed [WI-1:0] w_xn;
  logic signed [WI-1:0] w_yn;
  logic signed [WI-1:0] w_zn;
  logic signed [WI-1:0] w_atanh;
  logic [SHW-1:0]       w_shift;
  logic [SHW-1:0]       w_shift_tab [S];
  logic signed [WI-1:0] w_atanh_tab [S];
  logic signed [WI+1:0] w_val;
  logic signed [WI+1:0] w_rnd;
  logic [W-1:0]         w_sat;

  // Per-step shift index and angle, folding in the repeated indices.
  for (genvar s = 0; s < S; s++) begin : g_sched
    localparam int c_sh = shift_of_step(s, ITER);
    assign w_shift_tab[s] = SHW'(c_sh);
    assign w_atanh_tab[s] = WI'(atanh_fg(c_sh, FG));
  end

  assign w_shift = w_shift_tab[r_step];
  assign w_atanh = w_atanh_tab[r_step];
  assign w_last  = (r_step == STW'(S - 1));
  assign w_is_ln = (r_mode == MODE_LN);
  assign w_x_ext = {{EXT{r_x[W-1]}}, r_x, {GUARD{1'b0}}};

  assign w_range_bad = w_is_ln ? (r_x < c_ln_min)
                               : ((r_x > c_rot_max) || (r_x < -c_rot_max));

  cordic_hyp_step #(
    .WI  (WI),
    .SHW (SHW)
  ) u_step (
    .i_x     (r_xr),
    .i_y     (r_yr),
    .i_z     (r_zr),
    .i_shift (w_shift),
    .i_atanh (w_atanh),
    .i_vec   (w_is_ln),
    .o_x     (w_xn),
    .o_y     (w_yn),
    .o_z     (w_zn)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // A start coinciding with the done pulse is deliberately not accepted.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && !r_done) begin
          w_next   = ST_LOAD;
          w_accept = 1'b1;
        end
      end
      ST_LOAD: w_next = w_range_bad ? ST_FIN : ST_RUN;
      ST_RUN:  if (w_last) w_next = ST_FIN;
      ST_FIN:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_val = '0;
    case (r_mode)
      MODE_EXP:  w_val = {{2{r_xr[WI-1]}}, r_xr} + {{2{r_yr[WI-1]}}, r_yr};
      MODE_SINH: w_val = {{2{r_yr[WI-1]}}, r_yr};
      MODE_COSH: w_val = {{2{r_xr[WI-1]}}, r_xr};
      default:   w_val = {r_zr[WI-1], r_zr, 1'b0};
    endcase
    w_rnd = (w_val + c_half) >>> GUARD;
    if (w_rnd > c_res_max)      w_sat = c_res_max[W-1:0];
    else if (w_rnd < c_res_min) w_sat = c_res_min[W-1:0];
    else                        w_sat = w_rnd[W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode   <= MODE_EXP;
      r_x      <= '0;
      r_xr     <= '0;
      r_yr     <= '0;
      r_zr     <= '0;
      r_step   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_mode <= hyp_mode_e'(mode);
            r_x    <= x_in;
            r_busy <= 1'b1;
          end
        end
        ST_LOAD: begin
          r_step <= '0;
          if (!w_range_bad) begin
            if (w_is_ln) begin
              r_xr <= w_x_ext + c_one;
              r_yr <= w_x_ext - c_one;
              r_zr <= '0;
            end else begin
              r_xr <= c_inv_kh;
              r_yr <= '0;
              r_zr <= w_x_ext;
            end
          end
        end
        ST_RUN: begin
          r_xr   <= w_xn;
          r_yr   <= w_yn;
          r_zr   <= w_zn;
          r_step <= r_step + 1'b1;
        end
        ST_FIN: begin
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_err    <= w_range_bad;
          r_result <= w_range_bad ? '0 : w_sat;
        end
        default: ;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign err    = r_err;
  assign result = r_result;

endmodule
`default_nettype wire
